// File: rtl/mux_rr_arbiter_if.sv
// Bundle between requester logic and the round-robin arbiter in front of the shared 8:1 mux.
// Requesters drive req/d; the arbiter returns the select, one-hot grant, valid and mux output.
interface mux_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] d;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       valid;
  logic       out;

  modport master (output req, d, input sel, grant, valid, out);
  modport slave  (input req, d, output sel, grant, valid, out);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that time-shares an 8:1 single-bit mux among eight requesters,
// capping each grant at HOLD_MAX cycles and regranting back-to-back when possible.
module mux_8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);
  assign y = d[sel];
endmodule

module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_rr_arbiter_if.slave    bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  logic [0:0] state_r, state_s;
  logic [2:0] sel_r, sel_s;
  logic [7:0] grant_r, grant_s;
  logic       valid_r, valid_s;
  logic [2:0] ptr_r, ptr_s;
  logic [3:0] hold_cnt_r, hold_cnt_s;
  logic [3:0] pick_s;
  logic [2:0] search_base_s;
  logic       mux_y_s;

  // First requester at or after base, wrapping 7->0; result is {hit, index}.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // A grantee that gives up or times out is searched last from the slot after it.
  always_comb begin
    search_base_s = ptr_r;
    if (state_r == BUSY) begin
      search_base_s = sel_r + 3'd1;
    end else begin
      search_base_s = ptr_r;
    end
    pick_s = pick(bus.req, search_base_s);
  end

  // Next-state decode for the IDLE/BUSY arbitration sequencer.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    grant_s    = grant_r;
    valid_s    = valid_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s    = BUSY;
          sel_s      = pick_s[2:0];
          grant_s    = 8'b0000_0001 << pick_s[2:0];
          valid_s    = 1'b1;
          hold_cnt_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.req[sel_r] && (hold_cnt_r < HOLD_LAST)) begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end else begin
          ptr_s = sel_r + 3'd1;
          if (pick_s[3]) begin
            sel_s      = pick_s[2:0];
            grant_s    = 8'b0000_0001 << pick_s[2:0];
            valid_s    = 1'b1;
            hold_cnt_s = 4'd0;
          end else begin
            state_s    = IDLE;
            grant_s    = 8'h00;
            valid_s    = 1'b0;
            hold_cnt_s = 4'd0;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = 8'h00;
        valid_s    = 1'b0;
        hold_cnt_s = 4'd0;
      end
    endcase
  end

  // Arbitration state registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      sel_r      <= 3'd0;
      grant_r    <= 8'h00;
      valid_r    <= 1'b0;
      ptr_r      <= 3'd0;
      hold_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      grant_r    <= grant_s;
      valid_r    <= valid_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  mux_8_1 u_mux (
    .d   (bus.d),
    .sel (sel_r),
    .y   (mux_y_s)
  );

  assign bus.sel   = sel_r;
  assign bus.grant = grant_r;
  assign bus.valid = valid_r;
  assign bus.out   = valid_r & mux_y_s;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter (HOLD_MAX=4 and HOLD_MAX=1 instances)
// checked against a cycle-level behavioural model of the round-robin rules.
module tb_mux_rr_arbiter;
  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] d;

  int n_cmp;
  int n_mis;

  // model state per instance: 0 -> HOLD_MAX=4, 1 -> HOLD_MAX=1
  int m_g[2];
  int m_held[2];
  int m_ptr[2];
  int m_sel[2];
  int m_hold[2];

  mux_rr_arbiter_if bus4 ();
  mux_rr_arbiter_if bus1 ();

  assign bus4.req = req;
  assign bus4.d   = d;
  assign bus1.req = req;
  assign bus1.d   = d;

  mux_rr_arbiter #(.HOLD_MAX(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  mux_rr_arbiter #(.HOLD_MAX(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++) begin
      if (r[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_g[k] = -1; m_held[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
    end
  endtask

  // one rising edge of the arbitration rules, expressed as cycles-held vs the cap
  task automatic model_step(input int k, input logic [7:0] r);
    int p;
    if (m_g[k] < 0) begin
      p = first_req(r, m_ptr[k]);
      if (p >= 0) begin
        m_g[k] = p; m_sel[k] = p; m_held[k] = 1;
      end
    end else if (r[m_g[k]] && m_held[k] < m_hold[k]) begin
      m_held[k]++;
    end else begin
      m_ptr[k] = (m_g[k] + 1) % 8;
      p = first_req(r, m_ptr[k]);
      if (p >= 0) begin
        m_g[k] = p; m_sel[k] = p; m_held[k] = 1;
      end else begin
        m_g[k] = -1; m_held[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    logic       ev;
    logic       eo;
    for (int k = 0; k < 2; k++) begin
      ev = (m_g[k] >= 0);
      eg = ev ? (8'h01 << m_g[k]) : 8'h00;
      eo = ev ? d[m_sel[k]] : 1'b0;
      if (k == 0) begin
        chk({tag, "/h4.sel"},   32'(bus4.sel),   32'(m_sel[k]));
        chk({tag, "/h4.grant"}, 32'(bus4.grant), 32'(eg));
        chk({tag, "/h4.valid"}, 32'(bus4.valid), 32'(ev));
        chk({tag, "/h4.out"},   32'(bus4.out),   32'(eo));
      end else begin
        chk({tag, "/h1.sel"},   32'(bus1.sel),   32'(m_sel[k]));
        chk({tag, "/h1.grant"}, 32'(bus1.grant), 32'(eg));
        chk({tag, "/h1.valid"}, 32'(bus1.valid), 32'(ev));
        chk({tag, "/h1.out"},   32'(bus1.out),   32'(eo));
      end
    end
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] dd);
    req = r;
    d   = dd;
    @(posedge clk);
    model_step(0, req);
    model_step(1, req);
    #1;
    check_all(tag);
  endtask

  // reset asserted away from an edge; outputs must drop before the next edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] rr;
    logic [7:0] dd;
    n_cmp = 0;
    n_mis = 0;
    m_hold[0] = 4;
    m_hold[1] = 1;
    req   = 8'h00;
    d     = 8'h00;
    reset = 1'b0;
    #2;
    do_reset("reset");

    for (int i = 0; i < 10; i++) step("idle", 8'h00, 8'hFF);

    for (int i = 0; i < 14; i++) step("single2", 8'b0000_0100, 8'hEA);

    do_reset("reset2");
    for (int i = 0; i < 40; i++) step("all", 8'hFF, 8'h23);

    do_reset("reset3");
    step("drop5.a", 8'h20, 8'h5A);
    step("drop5.b", 8'h22, 8'h5A);
    step("drop5.c", 8'h02, 8'h5A);
    chk("drop5.next_sel", 32'(bus4.sel), 32'd1);

    do_reset("reset4");
    step("mid.a", 8'h08, 8'h08);
    step("mid.b", 8'h08, 8'h08);
    chk("mid.busy", 32'(bus4.valid), 32'd1);
    do_reset("mid.rst");
    step("mid.after", 8'h09, 8'h08);
    chk("mid.first_grant", 32'(bus4.grant), 32'h01);

    do_reset("reset5");
    for (int i = 0; i < 8; i++) step("alt81", 8'b1000_0001, 8'h81);

    rr = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: rr = 8'h00;
          1: rr = 8'h01 << $urandom_range(0, 7);
          2: rr = 8'($urandom) & 8'($urandom);
          default: rr = 8'($urandom);
        endcase
      end
      dd = 8'($urandom);
      step("rand", rr, dd);
      if (i == 200) do_reset("rand.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
